// File: rtl/fsm_states.sv
// Virtual-pet needs engine: five saturating 3-bit need levels decayed by a prescaled tick,
// with derived happiness/health and an internal ALIVE/CRITICAL/DEAD status machine.
`timescale 1ns / 1ps

module fsm_states #(
    parameter int unsigned TICK_DIV      = 5000,
    parameter int unsigned MAX_LEVEL     = 5,
    parameter int unsigned FOOD_PERIOD   = 3,
    parameter int unsigned SLEEP_PERIOD  = 5,
    parameter int unsigned FUN_PERIOD    = 2,
    parameter int unsigned HEALTH_PERIOD = 4,
    // Reset value of health; lets a bench start from a weakened pet.
    parameter int unsigned HEALTH_INIT   = MAX_LEVEL
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] foodValue,
    output logic [2:0] sleepValue,
    output logic [2:0] funValue,
    output logic [2:0] happyValue,
    output logic [2:0] healthValue
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PW = 8;

    typedef enum logic [1:0] {Alive = 2'd0, Critical = 2'd1, Dead = 2'd2} statusT;

    statusT        stateQ, stateD;
    logic [TW-1:0] tickQ, tickD;
    logic [PW-1:0] foodCntQ, foodCntD, sleepCntQ, sleepCntD;
    logic [PW-1:0] funCntQ, funCntD, healthCntQ, healthCntD;
    logic [2:0]    foodD, sleepD, funD, happyD, healthD;
    logic          tick, anyLow, allOk;
    logic [3:0]    needSum;

    function automatic logic [2:0] decSat(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    assign tick    = (tickQ == TW'(TICK_DIV - 1));
    assign needSum = {1'b0, foodValue} + {1'b0, funValue};
    assign anyLow  = (foodValue <= 3'd1) || (sleepValue <= 3'd1) ||
                     (funValue <= 3'd1) || (healthValue <= 3'd1);
    assign allOk   = (foodValue >= 3'd2) && (sleepValue >= 3'd2) &&
                     (funValue >= 3'd2) && (healthValue >= 3'd2);

    always_comb begin
        stateD     = stateQ;
        tickD      = tickQ;
        foodCntD   = foodCntQ;
        sleepCntD  = sleepCntQ;
        funCntD    = funCntQ;
        healthCntD = healthCntQ;
        foodD      = foodValue;
        sleepD     = sleepValue;
        funD       = funValue;
        happyD     = happyValue;
        healthD    = healthValue;

        // DEAD freezes every register, so only the non-dead path computes updates.
        if (stateQ != Dead) begin
            tickD = tick ? '0 : tickQ + 1'b1;
            if (tick) begin
                if (foodCntQ == PW'(FOOD_PERIOD - 1)) begin
                    foodCntD = '0;
                    foodD    = decSat(foodValue);
                end else begin
                    foodCntD = foodCntQ + 1'b1;
                end
                if (sleepCntQ == PW'(SLEEP_PERIOD - 1)) begin
                    sleepCntD = '0;
                    sleepD    = decSat(sleepValue);
                end else begin
                    sleepCntD = sleepCntQ + 1'b1;
                end
                if (funCntQ == PW'(FUN_PERIOD - 1)) begin
                    funCntD = '0;
                    funD    = decSat(funValue);
                end else begin
                    funCntD = funCntQ + 1'b1;
                end
                happyD = 3'(needSum >> 1);
                if (healthCntQ == PW'(HEALTH_PERIOD - 1)) begin
                    healthCntD = '0;
                    if (foodValue == 3'd0 || sleepValue == 3'd0) begin
                        healthD = decSat(healthValue);
                    end else if (happyValue >= 3'd3 && healthValue < 3'(MAX_LEVEL)) begin
                        healthD = healthValue + 3'd1;
                    end
                end else begin
                    healthCntD = healthCntQ + 1'b1;
                end
            end

            if (healthValue == 3'd0) begin
                stateD = Dead;
            end else if (stateQ == Alive && anyLow) begin
                stateD = Critical;
            end else if (stateQ == Critical && allOk) begin
                stateD = Alive;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ      <= Alive;
            tickQ       <= '0;
            foodCntQ    <= '0;
            sleepCntQ   <= '0;
            funCntQ     <= '0;
            healthCntQ  <= '0;
            foodValue   <= 3'(MAX_LEVEL);
            sleepValue  <= 3'(MAX_LEVEL);
            funValue    <= 3'(MAX_LEVEL);
            happyValue  <= 3'(MAX_LEVEL);
            healthValue <= 3'(HEALTH_INIT);
        end else begin
            stateQ      <= stateD;
            tickQ       <= tickD;
            foodCntQ    <= foodCntD;
            sleepCntQ   <= sleepCntD;
            funCntQ     <= funCntD;
            healthCntQ  <= healthCntD;
            foodValue   <= foodD;
            sleepValue  <= sleepD;
            funValue    <= funD;
            happyValue  <= happyD;
            healthValue <= healthD;
        end
    end

endmodule

// File: tb/tb_fsm_states.sv
// Directed bench for fsm_states: reset values, decay schedule, async reset, death and recovery.
`timescale 1ns / 1ps

module tb_fsm_states;

    logic clk;
    logic rstA, rstB, rstC, rstD;
    logic [2:0] foodA, sleepA, funA, happyA, healthA;
    logic [2:0] foodB, sleepB, funB, happyB, healthB;
    logic [2:0] foodC, sleepC, funC, happyC, healthC;
    logic [2:0] foodD, sleepD, funD, happyD, healthD;

    int nChecks = 0;
    int nFail   = 0;
    int maxC    = 0;
    int maxHealthD = 0;

    fsm_states dutA (
        .clk(clk), .rst(rstA), .foodValue(foodA), .sleepValue(sleepA), .funValue(funA),
        .happyValue(happyA), .healthValue(healthA)
    );

    fsm_states #(.TICK_DIV(4)) dutB (
        .clk(clk), .rst(rstB), .foodValue(foodB), .sleepValue(sleepB), .funValue(funB),
        .happyValue(happyB), .healthValue(healthB)
    );

    fsm_states #(.TICK_DIV(2)) dutC (
        .clk(clk), .rst(rstC), .foodValue(foodC), .sleepValue(sleepC), .funValue(funC),
        .happyValue(happyC), .healthValue(healthC)
    );

    fsm_states #(
        .TICK_DIV(2), .FOOD_PERIOD(50), .SLEEP_PERIOD(50), .FUN_PERIOD(50), .HEALTH_INIT(2)
    ) dutD (
        .clk(clk), .rst(rstD), .foodValue(foodD), .sleepValue(sleepD), .funValue(funD),
        .happyValue(happyD), .healthValue(healthD)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Track the largest level ever seen so a wrap to 7 or an overshoot to 6 is caught.
    always @(negedge clk) begin
        if (!rstC) begin
            if (int'(foodC) > maxC) maxC = int'(foodC);
            if (int'(sleepC) > maxC) maxC = int'(sleepC);
            if (int'(funC) > maxC) maxC = int'(funC);
            if (int'(happyC) > maxC) maxC = int'(happyC);
            if (int'(healthC) > maxC) maxC = int'(healthC);
        end
        if (!rstD && int'(healthD) > maxHealthD) maxHealthD = int'(healthD);
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land half a nanosecond after the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #0.5;
    endtask

    initial begin
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1; rstD = 1'b1;

        // Default parameters: nothing decays within 100 ns of release.
        #100 rstA = 1'b0;
        #100;
        checkVal("A.food", int'(foodA), 5);
        checkVal("A.sleep", int'(sleepA), 5);
        checkVal("A.fun", int'(funA), 5);
        checkVal("A.happy", int'(happyA), 5);
        checkVal("A.health", int'(healthA), 5);

        // TICK_DIV=4 schedule: fun at edge 8, food at 12, sleep at 20.
        @(negedge clk) rstB = 1'b0;
        edges(7);
        checkVal("B.e7.fun", int'(funB), 5);
        edges(1);
        checkVal("B.e8.fun", int'(funB), 4);
        checkVal("B.e8.happy", int'(happyB), 5);
        checkVal("B.e8.food", int'(foodB), 5);
        edges(3);
        checkVal("B.e11.food", int'(foodB), 5);
        edges(1);
        checkVal("B.e12.food", int'(foodB), 4);
        checkVal("B.e12.happy", int'(happyB), 4);
        edges(4);
        checkVal("B.e16.fun", int'(funB), 3);
        checkVal("B.e16.happy", int'(happyB), 4);
        checkVal("B.e16.health", int'(healthB), 5);
        edges(3);
        checkVal("B.e19.sleep", int'(sleepB), 5);
        edges(1);
        checkVal("B.e20.sleep", int'(sleepB), 4);
        checkVal("B.e20.happy", int'(happyB), 3);

        // Asynchronous reset between edges, then the same schedule again.
        edges(2);
        rstB = 1'b1;
        #0.2;
        checkVal("B.arst.food", int'(foodB), 5);
        checkVal("B.arst.sleep", int'(sleepB), 5);
        checkVal("B.arst.fun", int'(funB), 5);
        checkVal("B.arst.happy", int'(happyB), 5);
        checkVal("B.arst.health", int'(healthB), 5);
        checkVal("B.arst.state", int'(dutB.stateQ), 0);
        @(negedge clk) rstB = 1'b0;
        edges(7);
        checkVal("B.re7.fun", int'(funB), 5);
        edges(1);
        checkVal("B.re8.fun", int'(funB), 4);
        edges(3);
        checkVal("B.re11.food", int'(foodB), 5);
        edges(1);
        checkVal("B.re12.food", int'(foodB), 4);

        // TICK_DIV=2 run to death: fun hits 1 at edge 16, health hits 0 at edge 64.
        @(negedge clk) rstC = 1'b0;
        edges(16);
        checkVal("C.e16.fun", int'(funC), 1);
        checkVal("C.e16.state", int'(dutC.stateQ), 0);
        edges(1);
        checkVal("C.e17.state", int'(dutC.stateQ), 1);
        edges(46);
        checkVal("C.e63.health", int'(healthC), 1);
        edges(1);
        checkVal("C.e64.health", int'(healthC), 0);
        checkVal("C.e64.state", int'(dutC.stateQ), 1);
        edges(1);
        checkVal("C.e65.state", int'(dutC.stateQ), 2);
        edges(200);
        checkVal("C.dead.food", int'(foodC), 0);
        checkVal("C.dead.sleep", int'(sleepC), 0);
        checkVal("C.dead.fun", int'(funC), 0);
        checkVal("C.dead.happy", int'(happyC), 0);
        checkVal("C.dead.health", int'(healthC), 0);
        checkVal("C.dead.state", int'(dutC.stateQ), 2);
        checkVal("C.dead.tickFrozen", int'(dutC.tickQ), 1);
        checkVal("C.maxLevel", maxC, 5);
        rstC = 1'b1;
        #0.2;
        checkVal("C.rst.state", int'(dutC.stateQ), 0);
        checkVal("C.rst.health", int'(healthC), 5);

        // Recovery from health=2 with needs held high: +1 per health period, capped at 5.
        @(negedge clk) rstD = 1'b0;
        edges(7);
        checkVal("D.e7.health", int'(healthD), 2);
        edges(1);
        checkVal("D.e8.health", int'(healthD), 3);
        edges(7);
        checkVal("D.e15.health", int'(healthD), 3);
        edges(1);
        checkVal("D.e16.health", int'(healthD), 4);
        edges(8);
        checkVal("D.e24.health", int'(healthD), 5);
        edges(8);
        checkVal("D.e32.health", int'(healthD), 5);
        edges(48);
        checkVal("D.e80.health", int'(healthD), 5);
        checkVal("D.e80.happy", int'(happyD), 5);
        checkVal("D.maxHealth", maxHealthD, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFail);
        $finish;
    end

endmodule
